pwm_run_ctrl: RTL and testbench
===============================

# pwm_run_ctrl

Run/stop/fault sequencer for a group of `pwm_16bits` channels. It starts the channels with programmable per-channel delays for phase staggering. It stops each channel gracefully on its own carrier period event (`mask_event`). On an external trip it shuts everything down immediately and latches the fault. It sits between the AXI4-lite register file and the `pwm_onoff` inputs of the PWM instances, and it drives the gate-driver enable.

## Interface
- `N_CH`, 4, number of sequenced PWM channels
- `DLY_WIDTH`, 16, width of the start-delay values and the stagger counter
- `DRAIN_TO`, 65535, maximum clock cycles spent in DRAIN before the channels are forced off
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  run request, single-cycle pulse
- `stop`  in  1  graceful stop request, single-cycle pulse
- `fault`  in  1  external trip, active high, asynchronous to `clk`
- `fault_clr`  in  1  fault acknowledge, single-cycle pulse
- `start_delay`  in  N_CH*DLY_WIDTH  per-channel enable delay in `clk` cycles; channel i uses bits [i*DLY_WIDTH +: DLY_WIDTH]
- `mask_event`  in  N_CH  per-channel carrier period event from each PWM instance
- `pwm_onoff`  out  N_CH  per-channel enable (1 = PWM_ON)
- `gate_en`  out  1  gate-driver enable
- `busy`  out  1  high in STAGGER, RUN and DRAIN
- `fault_latched`  out  1  sticky trip flag
- `drain_timeout`  out  1  sticky flag, set when DRAIN ended by timeout; cleared by the next accepted `start`
- `state`  out  3  current FSM state encoding

## Operation
- `fault` passes through a 2-FF synchronizer; the synchronized signal is `fault_s`.
- Priority: `fault_s` > `stop` > `start`.
- States and encodings:
  - IDLE = 0
  - STAGGER = 1
  - RUN = 2
  - DRAIN = 3
  - FAULT = 4
- **IDLE:** all outputs 0 except the sticky flags.
  - `start` with `fault_s` = 0 → STAGGER; clear the counter to 0 and clear `drain_timeout`.
  - `start` together with `stop` in the same cycle → remain in IDLE.
- **STAGGER:**
  - The counter increments once per cycle and saturates at 2^DLY_WIDTH-1.
  - In the cycle where counter == delay_i, set `pwm_onoff[i]` on the next edge.
  - Once all N_CH bits are set → RUN.
  - `stop` → DRAIN.
- **RUN:** all `pwm_onoff` bits are 1. `stop` → DRAIN; `start` is ignored.
- **DRAIN:**
  - A channel with `pwm_onoff[i]` = 1 is cleared on the edge after its `mask_event[i]` is sampled high.
  - Channels not yet enabled stay 0.
  - When all bits are 0 → IDLE.
  - The drain counter increments each cycle. When it reaches DRAIN_TO, clear all bits, set `drain_timeout`, and go to IDLE.
- **FAULT:**
  - Entered from any state when `fault_s` = 1: clear all `pwm_onoff` bits and `gate_en` on the same edge, and set `fault_latched`.
  - Exit to IDLE only on `fault_clr` with `fault_s` = 0; this also clears `fault_latched`.
  - `start` and `stop` are ignored.
- `gate_en` = 1 in STAGGER and RUN, and in DRAIN while any `pwm_onoff` bit is 1; otherwise 0.
- `start_delay` is sampled live during STAGGER. Software must hold it stable from `start` until RUN.

## Timing
- Reset (`reset` = 0): state IDLE; `pwm_onoff` = 0, `gate_en` = 0, `busy` = 0, `fault_latched` = 0, `drain_timeout` = 0; counters and synchronizer cleared.
- Let `start` be sampled at edge k:
  - `state` = STAGGER and `gate_en` = 1 after edge k+1.
  - `pwm_onoff[i]` goes high after edge k+2+delay_i.
  - RUN is entered one edge after the last channel is enabled.
- `mask_event[i]` sampled at edge m → `pwm_onoff[i]` = 0 after edge m+1.
- Fault latency: `fault` rising → outputs forced low within 3 rising edges. Fault entry is combinationally independent of `start`, `stop` and `mask_event`.
- Reset asserted mid-operation → all outputs 0 immediately, asynchronously.
- All outputs are registered.

## Test plan
- Stagger start: N_CH=4, delays 0/10/20/30, `start` at edge 5 → `pwm_onoff` bits rise after edges 7/17/27/37; RUN after edge 38; `gate_en` high from edge 6.
- Graceful stop: in RUN, `stop`, then `mask_event` pulses on channels 2,0,3,1 at edges 100/110/120/130 → each bit clears one edge later; IDLE and `gate_en` = 0 after edge 132.
- Stop during STAGGER: delays 0/50/50/50, `stop` at counter 10 → only channel 0 drains; channels 1–3 never rise.
- Fault: assert `fault` in RUN → `pwm_onoff` = 0 and `gate_en` = 0 within 3 edges, `fault_latched` = 1. `fault_clr` while `fault` is high → stay in FAULT. Release `fault`, then `fault_clr` → IDLE.
- Drain timeout: DRAIN_TO=8, no `mask_event` → all bits forced 0 after 8 cycles in DRAIN; `drain_timeout` = 1, cleared by the next `start`.
- Priority: `start` and `stop` in the same IDLE cycle → stays IDLE. `start` with `fault` held high → no STAGGER; FAULT entered.

Source files
------------

// File: rtl/pwm_run_ctrl.sv
// rtl/pwm_run_ctrl.sv - run/stop/fault sequencer driving pwm_onoff and the gate-driver enable
// Control inputs are registered once; the trip input is synchronized and overrides every state.
module pwm_run_ctrl #(
  parameter int N_CH      = 4,
  parameter int DLY_WIDTH = 16,
  parameter int DRAIN_TO  = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      fault,
  input  logic                      fault_clr,
  input  logic [N_CH*DLY_WIDTH-1:0] start_delay,
  input  logic [N_CH-1:0]           mask_event,
  output logic [N_CH-1:0]           pwm_onoff,
  output logic                      gate_en,
  output logic                      busy,
  output logic                      fault_latched,
  output logic                      drain_timeout,
  output logic [2:0]                state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STAGGER = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  localparam int                   DW         = $clog2(DRAIN_TO + 1);
  localparam logic [DW-1:0]        DRAIN_LAST = DW'(DRAIN_TO);
  localparam logic [DLY_WIDTH-1:0] CNT_MAX    = '1;

  logic                 fault_meta_q, fault_s_q;
  logic                 start_q, stop_q, clr_q;
  logic [N_CH-1:0]      mask_q;
  logic [2:0]           state_q, state_d;
  logic [DLY_WIDTH-1:0] cnt_q, cnt_d;
  logic [DW-1:0]        drain_q, drain_d, drain_inc;
  logic [N_CH-1:0]      onoff_q, onoff_d;
  logic                 gate_q, gate_d;
  logic                 busy_q, busy_d;
  logic                 flt_q, flt_d;
  logic                 dto_q, dto_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    onoff_d   = onoff_q;
    flt_d     = flt_q;
    dto_d     = dto_q;
    drain_inc = drain_q + DW'(1);

    if (fault_s_q) begin
      state_d = S_FAULT;
      onoff_d = '0;
      flt_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_q && !stop_q) begin
            state_d = S_STAGGER;
            cnt_d   = '0;
            dto_d   = 1'b0;
          end
        end
        S_STAGGER: begin
          if (stop_q) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else if (&onoff_q) begin
            state_d = S_RUN;
          end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + DLY_WIDTH'(1);
            for (int i = 0; i < N_CH; i++) begin
              if (cnt_q == start_delay[i*DLY_WIDTH +: DLY_WIDTH]) onoff_d[i] = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (stop_q) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
        S_DRAIN: begin
          // Emptying naturally takes precedence over the timeout in the same cycle.
          if (onoff_q == '0) begin
            state_d = S_IDLE;
          end else if (drain_inc == DRAIN_LAST) begin
            state_d = S_IDLE;
            onoff_d = '0;
            dto_d   = 1'b1;
          end else begin
            drain_d = drain_inc;
            onoff_d = onoff_q & ~mask_q;
          end
        end
        S_FAULT: begin
          if (clr_q) begin
            state_d = S_IDLE;
            flt_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          onoff_d = '0;
        end
      endcase
    end

    gate_d = (state_d == S_STAGGER) || (state_d == S_RUN) ||
             ((state_d == S_DRAIN) && (onoff_d != '0));
    busy_d = (state_d == S_STAGGER) || (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_meta_q <= 1'b0;
      fault_s_q    <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      clr_q        <= 1'b0;
      mask_q       <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      drain_q      <= '0;
      onoff_q      <= '0;
      gate_q       <= 1'b0;
      busy_q       <= 1'b0;
      flt_q        <= 1'b0;
      dto_q        <= 1'b0;
    end else begin
      fault_meta_q <= fault;
      fault_s_q    <= fault_meta_q;
      start_q      <= start;
      stop_q       <= stop;
      clr_q        <= fault_clr;
      mask_q       <= mask_event;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      onoff_q      <= onoff_d;
      gate_q       <= gate_d;
      busy_q       <= busy_d;
      flt_q        <= flt_d;
      dto_q        <= dto_d;
    end
  end

  assign pwm_onoff     = onoff_q;
  assign gate_en       = gate_q;
  assign busy          = busy_q;
  assign fault_latched = flt_q;
  assign drain_timeout = dto_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pwm_run_ctrl.sv
// tb/tb_pwm_run_ctrl.sv - scoreboard bench for pwm_run_ctrl driven by randomized scenarios
// Expected traces come from event times (start/stop/mask/fault edges), not from a state machine.
module tb_pwm_run_ctrl;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int DTO  = 90;
  localparam int BIG  = 1000000;
  localparam int TMAX = 400;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STAGGER = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  typedef logic [10:0] exp_t;  // {state, onoff[3:0], gate, busy, fault_latched, drain_timeout}

  logic           clk = 1'b0;
  logic           reset, start, stop, fault, fault_clr;
  logic [N*W-1:0] start_delay;
  logic [N-1:0]   mask_event, pwm_onoff;
  logic           gate_en, busy, fault_latched, drain_timeout;
  logic [2:0]     state;

  always #5 clk = ~clk;

  pwm_run_ctrl #(.N_CH(N), .DLY_WIDTH(W), .DRAIN_TO(DTO)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .fault(fault),
    .fault_clr(fault_clr), .start_delay(start_delay), .mask_event(mask_event),
    .pwm_onoff(pwm_onoff), .gate_en(gate_en), .busy(busy),
    .fault_latched(fault_latched), .drain_timeout(drain_timeout), .state(state)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic         st_a[TMAX], sp_a[TMAX], ft_a[TMAX], cl_a[TMAX];
  logic [N-1:0] mk_a[TMAX];
  int           dly[N], sm[N];
  int           sk, sp, sf, sh, sc, both_at;
  logic         dto_model = 1'b0;

  function automatic exp_t dut_out();
    return {state, pwm_onoff, gate_en, busy, fault_latched, drain_timeout};
  endfunction

  task automatic report(input string name, input exp_t a, input exp_t e);
    $display("FAIL %s t=%0t got st=%0d on=%b g=%b b=%b fl=%b dt=%b want st=%0d on=%b g=%b b=%b fl=%b dt=%b",
             name, $time, a[10:8], a[7:4], a[3], a[2], a[1], a[0],
             e[10:8], e[7:4], e[3], e[2], e[1], e[0]);
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_out();
        checks++;
        if (a !== e) begin
          errors++;
          report("cycle_out", a, e);
        end
      end
    end
  end

  task automatic clr_scn();
    sk = BIG; sp = BIG; sf = BIG; sh = 0; sc = BIG; both_at = -1;
    for (int i = 0; i < N; i++) sm[i] = BIG;
  endtask

  task automatic run_scn();
    int           maxd, run_e, drain_e, idle_e, te, z, tl;
    int           on_e[N], off_e[N];
    logic         en[N];
    logic         timeout, d_t;
    logic [2:0]   s;
    logic [N-1:0] b;
    maxd = 0;
    for (int i = 0; i < N; i++) if (dly[i] > maxd) maxd = dly[i];
    run_e   = sk + 3 + maxd;
    drain_e = (sp < BIG) ? sp + 1 : BIG;
    te      = drain_e + DTO;
    z       = drain_e;
    for (int i = 0; i < N; i++) begin
      on_e[i]  = sk + 2 + dly[i];
      en[i]    = (on_e[i] <= sp);
      off_e[i] = BIG;
      if (en[i] && sp < BIG) begin
        off_e[i] = (sm[i] < BIG) ? sm[i] + 1 : BIG;
        if (off_e[i] > z) z = off_e[i];
      end
    end
    timeout = (sp < BIG) && (z >= te);
    if (timeout) begin
      for (int i = 0; i < N; i++) if (off_e[i] > te) off_e[i] = te;
      idle_e = te;
    end else begin
      idle_e = (sp < BIG) ? z + 1 : BIG;
    end
    if (sf < BIG)      tl = sc + 4;
    else if (sp < BIG) tl = idle_e + 4;
    else               tl = 12;

    for (int t = 0; t < TMAX; t++) begin
      st_a[t] = 1'b0; sp_a[t] = 1'b0; ft_a[t] = 1'b0; cl_a[t] = 1'b0; mk_a[t] = '0;
    end
    for (int t = 0; t < tl; t++)
      if (t <= sp && $urandom_range(0, 11) == 0) mk_a[t][$urandom_range(0, N-1)] = 1'b1;
    if (sk < BIG) st_a[sk] = 1'b1;
    if (sp < BIG) begin
      sp_a[sp]     = 1'b1;
      st_a[sp + 1] = 1'b1;
      if (run_e <= sp - 1) st_a[run_e] = 1'b1;
    end
    for (int i = 0; i < N; i++) if (sm[i] < tl) mk_a[sm[i]][i] = 1'b1;
    if (sf < BIG) begin
      for (int t = sf; t < sf + sh; t++) ft_a[t] = 1'b1;
      cl_a[sf + 2] = 1'b1;
      cl_a[sc]     = 1'b1;
      st_a[sf + 3] = 1'b1;
    end
    if (both_at >= 0) begin
      st_a[both_at] = 1'b1; sp_a[both_at] = 1'b1; sp_a[both_at + 3] = 1'b1;
    end
    for (int i = 0; i < N; i++) start_delay[i*W +: W] = 16'(dly[i]);

    d_t = dto_model;
    for (int t = 0; t < tl; t++) begin
      s = ST_IDLE;
      if (t >= sk + 1 && t < idle_e) begin
        if (t >= drain_e)    s = ST_DRAIN;
        else if (t >= run_e) s = ST_RUN;
        else                 s = ST_STAGGER;
      end
      for (int i = 0; i < N; i++) b[i] = en[i] && (t >= on_e[i]) && (t < off_e[i]);
      if (sf < BIG && t >= sf + 2) begin
        b = '0;
        s = (t <= sc) ? ST_FAULT : ST_IDLE;
      end
      d_t = dto_model;
      if (sk + 1 < sf + 2 && t >= sk + 1) d_t = 1'b0;
      if (timeout && t >= te) d_t = 1'b1;
      start = st_a[t]; stop = sp_a[t]; fault = ft_a[t]; fault_clr = cl_a[t]; mask_event = mk_a[t];
      exp_q.push_back({s, b,
                       (s == ST_STAGGER) || (s == ST_RUN) || ((s == ST_DRAIN) && (b != '0)),
                       (s == ST_STAGGER) || (s == ST_RUN) || (s == ST_DRAIN),
                       (sf < BIG) && (t >= sf + 2) && (t <= sc),
                       d_t});
      @(posedge clk);
      #2;
    end
    dto_model = d_t;
    start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0; mask_event = '0;
  endtask

  initial begin
    int   maxd, kind;
    exp_t a;
    reset = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    mask_event = '0; start_delay = '0;
    #22;
    a = dut_out();
    checks++;
    if (a !== 11'd0) begin errors++; report("reset_state", a, 11'd0); end
    reset = 1'b1;
    @(posedge clk);
    #2;

    // Stagger 0/10/20/30 then graceful drain in channel order 2,0,3,1.
    clr_scn(); dly = '{0, 10, 20, 30}; sk = 5; sp = 45;
    sm[2] = 100; sm[0] = 110; sm[3] = 120; sm[1] = 130;
    run_scn();
    // Stop during stagger: only channel 0 was ever enabled.
    clr_scn(); dly = '{0, 50, 50, 50}; sk = 5; sp = 16; sm[0] = 21;
    run_scn();
    // Drain timeout with no carrier events.
    clr_scn(); dly = '{3, 1, 4, 2}; sk = 2; sp = 20;
    run_scn();
    // Trip while running, with an acknowledge attempted while trip is still high.
    clr_scn(); dly = '{1, 2, 3, 4}; sk = 2; sf = 15; sh = 5; sc = 22;
    run_scn();
    // Start and stop together in IDLE.
    clr_scn(); dly = '{0, 0, 0, 0}; both_at = 3;
    run_scn();
    // Start while trip already asserted.
    clr_scn(); dly = '{2, 2, 2, 2}; sk = 4; sf = 3; sh = 4; sc = 9;
    run_scn();

    for (int n = 0; n < 24; n++) begin
      clr_scn();
      maxd = 0;
      for (int i = 0; i < N; i++) begin
        dly[i] = $urandom_range(0, 40);
        if (dly[i] > maxd) maxd = dly[i];
      end
      sk   = $urandom_range(1, 5);
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        sp = sk + 1 + $urandom_range(0, maxd + 15);
        for (int i = 0; i < N; i++)
          sm[i] = ($urandom_range(0, 4) == 0) ? BIG : sp + 1 + $urandom_range(0, 99);
      end else if (kind == 2) begin
        sf = sk - 1 + $urandom_range(0, maxd + 12);
        sh = $urandom_range(3, 8);
        sc = sf + sh + 1 + $urandom_range(0, 3);
      end else begin
        sk = BIG;
        both_at = $urandom_range(1, 4);
      end
      run_scn();
    end

    // Asynchronous reset in the middle of a stagger.
    dly = '{0, 0, 0, 0};
    start_delay = '0;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    a = dut_out();
    checks++;
    if (a !== 11'd0) begin errors++; report("async_reset", a, 11'd0); end
    #2;
    reset = 1'b1;
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
